rv32i_lsu: RTL

Load/store unit forming the MEMORY stage directly downstream of the EXECUTE-stage ALU. It takes the registered ALU result as the effective address, then runs one data-bus transaction per load or store with a req/ack handshake and an ack timeout. Store data is lane-aligned with byte strobes; load data is extracted and sign- or zero-extended. The unit reports completion to stage control and flags misaligned, illegal and timed-out accesses.

---
 rtl/rv32i_lsu.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_lsu.sv
// rv32i_lsu -- RV32I load/store unit (MEMORY stage).
//
// Takes the registered ALU result as the effective address. Each load or
// store becomes one data-bus transaction with a req/ack handshake. If no
// ack arrives within TIMEOUT request cycles, the transaction is abandoned
// with a bus error. Store data is replicated across byte lanes, and byte
// strobes select the lanes. Load data is picked from its lane and then
// sign- or zero-extended.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle pulse when the instruction enters MEMORY
//   is_load/is_store  access kind, sampled with start (both set = load)
//   funct3            access width/signedness (B, H, W, BU, HU)
//   addr, rs2         effective address and store source data
//   d_req/d_we/d_addr/d_wdata/d_wstrb   data-bus request side
//   d_ack/d_rdata     data-bus response side
//   load_data         extended load result, held until the next load completes
//   done              one-cycle completion pulse
//   busy              transaction in progress (state != IDLE)
//   misaligned        with done: misaligned or illegal access, no bus cycle
//   bus_err           with done: ack timeout
module rv32i_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    output logic [3:0]  d_wstrb,
    input  logic        d_ack,
    input  logic [31:0] d_rdata,
    output logic [31:0] load_data,
    output logic        done,
    output logic        busy,
    output logic        misaligned,
    output logic        bus_err
);

    // The counter only has to reach TIMEOUT-1. On that REQ cycle, if ack is
    // still absent, the request is abandoned.
    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic          d_req_q, d_req_d;
    logic          d_we_q, d_we_d;
    logic [31:0]   d_addr_q, d_addr_d;
    logic [31:0]   d_wdata_q, d_wdata_d;
    logic [3:0]    d_wstrb_q, d_wstrb_d;
    logic [31:0]   load_data_q, load_data_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          misaligned_q, misaligned_d;
    logic          bus_err_q, bus_err_d;

    logic          req_store;
    logic          req_bad;
    logic [31:0]   st_wdata;
    logic [3:0]    st_wstrb;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   rd_ext;

    // Classify the incoming request. When both is_load and is_store are
    // set, the access is treated as a load. Stores have no unsigned
    // variants, so funct3[2] on a store is illegal.
    always_comb begin
        req_store = is_store & ~is_load;
        req_bad   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11)
                 || (req_store && funct3[2])
                 || ((funct3[1:0] == 2'b01) && addr[0])
                 || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Replicate store data into every lane. The strobes then pick the lanes
    // that the address actually targets.
    always_comb begin
        st_wdata = rs2;
        st_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{rs2[7:0]}};
                st_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{rs2[15:0]}};
                st_wstrb = 4'b0011 << addr[1:0];
            end
            default: begin
                st_wdata = rs2;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Pick the addressed byte or halfword from the returned word, then
    // extend it according to the funct3 value latched at request time.
    always_comb begin
        case (off_q)
            2'b00:   rd_byte = d_rdata[7:0];
            2'b01:   rd_byte = d_rdata[15:8];
            2'b10:   rd_byte = d_rdata[23:16];
            default: rd_byte = d_rdata[31:24];
        endcase
        rd_half = off_q[1] ? d_rdata[31:16] : d_rdata[15:0];
        case (f3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_ext = {24'h000000, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_ext = {16'h0000, rd_half};
            default: rd_ext = d_rdata;
        endcase
    end

    // Next-state and output logic. done and busy are derived from the next
    // state, so their registered values always match the state register.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        off_d        = off_q;
        d_req_d      = d_req_q;
        d_we_d       = d_we_q;
        d_addr_d     = d_addr_q;
        d_wdata_d    = d_wdata_q;
        d_wstrb_d    = d_wstrb_q;
        load_data_d  = load_data_q;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (!(is_load || is_store)) begin
                        state_d = S_DONE;
                    end else if (req_bad) begin
                        state_d      = S_DONE;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d   = S_REQ;
                        cnt_d     = '0;
                        f3_d      = funct3;
                        off_d     = addr[1:0];
                        d_req_d   = 1'b1;
                        d_we_d    = req_store;
                        d_addr_d  = {addr[31:2], 2'b00};
                        d_wdata_d = req_store ? st_wdata : 32'h0;
                        d_wstrb_d = req_store ? st_wstrb : 4'b0000;
                    end
                end
            end
            S_REQ: begin
                // An ack on the last permitted cycle still completes normally.
                if (d_ack) begin
                    state_d = S_DONE;
                    d_req_d = 1'b0;
                    if (!d_we_q) begin
                        load_data_d = rd_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    d_req_d   = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                d_req_d = 1'b0;
            end
        endcase

        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            d_req_q      <= 1'b0;
            d_we_q       <= 1'b0;
            d_addr_q     <= 32'h0;
            d_wdata_q    <= 32'h0;
            d_wstrb_q    <= 4'b0000;
            load_data_q  <= 32'h0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            d_req_q      <= d_req_d;
            d_we_q       <= d_we_d;
            d_addr_q     <= d_addr_d;
            d_wdata_q    <= d_wdata_d;
            d_wstrb_q    <= d_wstrb_d;
            load_data_q  <= load_data_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign d_req      = d_req_q;
    assign d_we       = d_we_q;
    assign d_addr     = d_addr_q;
    assign d_wdata    = d_wdata_q;
    assign d_wstrb    = d_wstrb_q;
    assign load_data  = load_data_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;

endmodule
